// File: rtl/sha2_msg_sched_seq.sv
// SHA-2 message scheduler built on a 16-word sliding window.
// It takes one 16-word block and then streams W[0..ROUNDS-1], one word per handshake.
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
// A producer holds its payload stable while valid is high and ready is low.
module sha2_msg_sched_seq #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64,
    parameter int IDX_W  = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   blk_valid_i,
    output logic                   blk_ready_o,
    input  logic [16*WORD_W-1:0]   blk_data_i,
    output logic                   w_valid_o,
    input  logic                   w_ready_i,
    output logic [WORD_W-1:0]      w_data_o,
    output logic [IDX_W-1:0]       w_idx_o,
    output logic                   w_last_o,
    output logic                   dbg_state_o
);

    // Rotation and shift amounts for the sigma functions of each family.
    localparam int S0_A = (WORD_W == 64) ? 1  : 7;
    localparam int S0_B = (WORD_W == 64) ? 8  : 18;
    localparam int S0_C = (WORD_W == 64) ? 7  : 3;
    localparam int S1_A = (WORD_W == 64) ? 19 : 17;
    localparam int S1_B = (WORD_W == 64) ? 61 : 19;
    localparam int S1_C = (WORD_W == 64) ? 6  : 10;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    // Reject parameter sets that do not describe a real SHA-2 schedule.
    if (!((WORD_W == 32 && ROUNDS == 64) || (WORD_W == 64 && ROUNDS == 80))) begin : g_bad_family
        $error("sha2_msg_sched_seq: WORD_W/ROUNDS must be 32/64 or 64/80");
    end
    if (ROUNDS > (1 << IDX_W)) begin : g_bad_idx
        $error("sha2_msg_sched_seq: IDX_W too narrow for ROUNDS");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] window_q [16];
    logic [WORD_W-1:0] window_d [16];
    logic [IDX_W-1:0]  t_q, t_d;
    logic [WORD_W-1:0] new_word;
    logic              blk_fire;
    logic              w_fire;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        return rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_C);
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        return rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_C);
    endfunction

    assign blk_fire = blk_valid_i && blk_ready_o;
    assign w_fire   = w_valid_o && w_ready_i;

    // State register: reset discards any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE until a block arrives, RUN until the last word is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (blk_fire) state_d = S_RUN;
            S_RUN:  if (w_fire && (t_q == LAST_IDX)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: everything is registered state or a select of window[0].
    always_comb begin
        blk_ready_o = (state_q == S_IDLE) && !rst;
        w_valid_o   = (state_q == S_RUN);
        w_data_o    = (state_q == S_RUN) ? window_q[0] : '0;
        w_idx_o     = (state_q == S_RUN) ? t_q : '0;
        w_last_o    = (state_q == S_RUN) && (t_q == LAST_IDX);
        dbg_state_o = state_q;
    end

    // Next schedule word from the pre-shift window (this adder is the critical path).
    always_comb begin
        new_word = sigma1(window_q[14]) + window_q[9] + sigma0(window_q[1]) + window_q[0];
    end

    // Window/counter next state: load on block accept, slide on each accepted word.
    always_comb begin
        t_d = t_q;
        for (int k = 0; k < 16; k++) begin
            window_d[k] = window_q[k];
        end
        if (state_q == S_IDLE) begin
            if (blk_fire) begin
                for (int k = 0; k < 16; k++) begin
                    window_d[k] = blk_data_i[(16-k)*WORD_W-1 -: WORD_W];
                end
                t_d = '0;
            end
        end else if (w_fire) begin
            if (t_q != LAST_IDX) begin
                for (int k = 0; k < 15; k++) begin
                    window_d[k] = window_q[k+1];
                end
                window_d[15] = new_word;
                t_d          = t_q + IDX_W'(1);
            end else begin
                t_d = '0;
            end
        end
    end

    // Window and counter registers; the window needs no reset since it is reloaded per block.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_q <= '0;
        end else begin
            t_q <= t_d;
        end
        for (int k = 0; k < 16; k++) begin
            window_q[k] <= window_d[k];
        end
    end

endmodule

// File: tb/tb_sha2_msg_sched_seq.sv
// Testbench for sha2_msg_sched_seq: drives a SHA-256 and a SHA-512 instance.
// One instance is active at a time. A queue-based scoreboard checks every word
// against a full-schedule reference model.
module tb_sha2_msg_sched_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  // ---------------- shared stimulus ----------------
  logic        sel = 1'b0;           // 0: SHA-256 instance, 1: SHA-512 instance
  logic        blk_valid = 1'b0;
  logic        w_ready = 1'b0;
  logic [63:0] blk_w [16];
  logic        force_low = 1'b0;
  int          stall_pct = 0;

  logic [511:0]  blk_data32;
  logic [1023:0] blk_data64;
  always_comb begin
    blk_data32 = '0;
    blk_data64 = '0;
    for (int k = 0; k < 16; k++) begin
      blk_data32[(16-k)*32-1 -: 32] = blk_w[k][31:0];
      blk_data64[(16-k)*64-1 -: 64] = blk_w[k];
    end
  end

  // ---------------- DUTs ----------------
  logic        br32, wv32, wl32, ds32;
  logic [31:0] wd32;
  logic [6:0]  wi32;
  logic        br64, wv64, wl64, ds64;
  logic [63:0] wd64;
  logic [6:0]  wi64;

  sha2_msg_sched_seq #(.WORD_W(32), .ROUNDS(64), .IDX_W(7)) dut32 (
    .clk(clk), .rst(rst), .blk_valid_i(blk_valid && !sel), .blk_ready_o(br32),
    .blk_data_i(blk_data32), .w_valid_o(wv32), .w_ready_i(w_ready), .w_data_o(wd32),
    .w_idx_o(wi32), .w_last_o(wl32), .dbg_state_o(ds32));

  sha2_msg_sched_seq #(.WORD_W(64), .ROUNDS(80), .IDX_W(7)) dut64 (
    .clk(clk), .rst(rst), .blk_valid_i(blk_valid && sel), .blk_ready_o(br64),
    .blk_data_i(blk_data64), .w_valid_o(wv64), .w_ready_i(w_ready), .w_data_o(wd64),
    .w_idx_o(wi64), .w_last_o(wl64), .dbg_state_o(ds64));

  logic        cur_valid, cur_last, cur_blk_ready;
  logic [63:0] cur_data;
  logic [6:0]  cur_idx;
  assign cur_valid     = sel ? wv64 : wv32;
  assign cur_last      = sel ? wl64 : wl32;
  assign cur_blk_ready = sel ? br64 : br32;
  assign cur_data      = sel ? wd64 : {32'h0, wd32};
  assign cur_idx       = sel ? wi64 : wi32;

  // ---------------- back-pressure generator ----------------
  initial forever begin
    @(posedge clk); #2;
    w_ready = !force_low && ($urandom_range(99) >= stall_pct);
  end

  // ---------------- reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [71:0] exp_q[$];   // {last, idx[6:0], data[63:0]}

  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    logic [63:0] v;
    v = x & wmask(w);
    return ((v >> n) | (v << (w - n))) & wmask(w);
  endfunction

  function automatic logic [63:0] s0(input logic [63:0] x, input int w);
    if (w == 32) return rotr(x, 7, w) ^ rotr(x, 18, w) ^ ((x & wmask(w)) >> 3);
    return rotr(x, 1, w) ^ rotr(x, 8, w) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] s1(input logic [63:0] x, input int w);
    if (w == 32) return rotr(x, 17, w) ^ rotr(x, 19, w) ^ ((x & wmask(w)) >> 10);
    return rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6);
  endfunction

  // Full schedule for the current block, pushed in emission order.
  task automatic push_expected();
    logic [63:0] ws [80];
    int w, r;
    w = sel ? 64 : 32;
    r = sel ? 80 : 64;
    for (int t = 0; t < r; t++) begin
      if (t < 16) ws[t] = blk_w[t] & wmask(w);
      else ws[t] = (s1(ws[t-2], w) + ws[t-7] + s0(ws[t-15], w) + ws[t-16]) & wmask(w);
      exp_q.push_back({(t == r - 1), 7'(t), ws[t]});
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [63:0] obs [80];
  int n_hs = 0;
  int n_last = 0;
  int last_hs_cyc = 0;
  int gap_meas = -1;
  bit gap_arm = 1'b0;

  always @(negedge clk) begin
    logic [71:0] e;
    if (!rst && cur_valid) begin
      if (gap_arm) begin
        gap_meas = cyc - last_hs_cyc;
        gap_arm  = 1'b0;
      end
      checks++;
      if (cur_blk_ready !== 1'b0) begin
        errors++;
        $display("FAIL blk_ready_in_run: got %b want 0 (idx %0d)", cur_blk_ready, cur_idx);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: idx %0d data %h with empty queue", cur_idx, cur_data);
      end else begin
        e = exp_q[0];
        if ({cur_last, cur_idx, cur_data} !== e) begin
          errors++;
          $display("FAIL word: got last=%b idx=%0d data=%h want last=%b idx=%0d data=%h",
                   cur_last, cur_idx, cur_data, e[71], e[70:64], e[63:0]);
        end
        if (w_ready) begin
          void'(exp_q.pop_front());
          obs[cur_idx] = cur_data;
          n_hs++;
          if (cur_last) begin
            n_last++;
            last_hs_cyc = cyc;
            gap_arm = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic rand_block();
    for (int k = 0; k < 16; k++) blk_w[k] = {$urandom, $urandom};
  endtask

  // Offer the current block until accepted; optionally keep blk_valid high afterwards.
  task automatic send_block(input bit hold);
    bit done;
    done = 1'b0;
    blk_valid = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (cur_blk_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL block_accept_timeout: got no blk_ready want blk_ready=1");
    end else begin
      push_expected();
    end
    if (!hold) blk_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      if (exp_q.size() == 0 && !cur_valid) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic clear_stats();
    n_hs = 0; n_last = 0;
    for (int k = 0; k < 80; k++) obs[k] = '0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit found;
    for (int k = 0; k < 16; k++) blk_w[k] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_blk_ready", cur_blk_ready, 0);
    check("rst_w_valid", cur_valid, 0);
    check("rst_w_idx", cur_idx, 0);
    check("rst_w_data", cur_data, 0);
    check("rst_w_last", cur_last, 0);
    rst = 1'b0;
    #1;
    check("post_rst_blk_ready", cur_blk_ready, 1);

    // SHA-256 "abc"
    sel = 1'b0; stall_pct = 0; clear_stats();
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) blk_w[k] = '0;
    blk_w[0] = 64'h6162_6380; blk_w[15] = 64'h18;
    send_block(1'b0);
    wait_done();
    check("abc256_w0", obs[0], 64'h6162_6380);
    check("abc256_w16", obs[16], 64'h6162_6380);
    check("abc256_w17", obs[17], 64'h000F_0000);
    check("abc256_hs", n_hs, 64);
    check("abc256_last", n_last, 1);

    // SHA-512 "abc"
    sel = 1'b1; clear_stats();
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) blk_w[k] = '0;
    blk_w[0] = 64'h6162_6380_0000_0000; blk_w[15] = 64'h18;
    send_block(1'b0);
    wait_done();
    check("abc512_w16", obs[16], 64'h6162_6380_0000_0000);
    check("abc512_hs", n_hs, 80);
    check("abc512_last", n_last, 1);

    // Back-pressure: stalled words must match the queue head throughout.
    sel = 1'b0; stall_pct = 30; clear_stats();
    @(posedge clk); #1;
    rand_block();
    send_block(1'b0);
    wait_done();
    check("stall_hs", n_hs, 64);
    stall_pct = 0;

    // Back-to-back blocks with blk_valid held high.
    @(posedge clk); #1;
    rand_block();
    send_block(1'b1);
    rand_block();
    send_block(1'b0);
    wait_done();
    check("b2b_gap", gap_meas, 2);

    // Reset in the middle of a block.
    @(posedge clk); #1;
    rand_block();
    send_block(1'b0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (cur_valid && cur_idx == 7'd20) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("mid_found_idx20", found, 1);
    rst = 1'b1; force_low = 1'b1;
    #1;
    check("mid_rst_blk_ready_now", cur_blk_ready, 0);
    @(posedge clk); #1;
    exp_q.delete();
    check("mid_rst_w_valid", cur_valid, 0);
    check("mid_rst_w_idx", cur_idx, 0);
    check("mid_rst_blk_ready", cur_blk_ready, 0);
    rst = 1'b0; force_low = 1'b0;
    #1;
    check("mid_post_blk_ready", cur_blk_ready, 1);
    @(posedge clk); #1;
    clear_stats();
    rand_block();
    send_block(1'b0);
    wait_done();
    check("mid_restart_hs", n_hs, 64);

    // Random blocks on both instances with mixed back-pressure.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      @(posedge clk); #1;
      for (int b = 0; b < 250; b++) begin
        case ($urandom_range(3))
          0: stall_pct = 10;
          1: stall_pct = 30;
          default: stall_pct = 0;
        endcase
        rand_block();
        send_block($urandom_range(1) == 1);
      end
      blk_valid = 1'b0;
      wait_done();
      stall_pct = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
